cosx: RTL and testbench

- Fixed-point cosine unit. It evaluates cos(x) by a truncated Taylor series, 1 - x²/2! + x⁴/4! - …, using a controller FSM plus a datapath (controller + dp).
- Terms are generated by recurrence: t_k = t_{k-1}·x²·c_k, with c_k = 1/(2k(2k-1)).
- Evaluation stops after 8 terms, or earlier once a term drops to or below the threshold y.
- Standalone arithmetic block with a start/done handshake. FSM state, counter carry and sign are exported for debug.

---
 rtl/cosx.sv | 114 +++++++++++
 tb/tb_cosx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cosx.sv
// Fixed-point cosine by truncated Taylor series, one shared multiplier chain.
// Terms follow t_k = t_{k-1} * x^2 * c_k and are summed with alternating sign.
module cosx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] x,
  input  logic [7:0] y,
  output logic       done,
  output logic [9:0] result,
  output logic [2:0] ps,
  output logic       co,
  output logic       is_neg
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StInit = 3'd2,
    StCalc = 3'd3,
    StAcc  = 3'd4,
    StDone = 3'd5
  } state_e;

  state_e      state_q;
  logic [9:0]  term_q;
  logic [9:0]  x2_q;
  logic [9:0]  result_q;
  logic [2:0]  cnt_q;
  logic [7:0]  y_q;

  logic [7:0]  coef;
  logic [9:0]  mul_a, mul_b;
  logic [19:0] prod;
  logic [11:0] prod_sh;
  logic [19:0] coef_prod;
  logic [9:0]  x2_next;
  logic [9:0]  term_next;
  logic        gt;

  always_comb begin
    coef = 8'd1;
    unique case (cnt_q)
      3'd0: coef = 8'd128;
      3'd1: coef = 8'd21;
      3'd2: coef = 8'd9;
      3'd3: coef = 8'd5;
      3'd4: coef = 8'd3;
      3'd5: coef = 8'd2;
      3'd6: coef = 8'd1;
      3'd7: coef = 8'd1;
      default: coef = 8'd1;
    endcase
  end

  // INIT squares x; CALC reuses the same multiplier for term * x^2.
  always_comb begin
    mul_a = term_q;
    mul_b = x2_q;
    if (state_q == StInit) begin
      mul_a = x;
      mul_b = x;
    end
  end

  assign prod      = 20'(mul_a) * 20'(mul_b);
  assign prod_sh   = 12'(prod >> 8);
  assign coef_prod = 20'(prod_sh) * 20'(coef);
  assign x2_next   = 10'(prod >> 8);
  assign term_next = 10'(coef_prod >> 8);
  assign gt        = term_q > {2'b00, y_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      term_q   <= 10'd0;
      x2_q     <= 10'd0;
      result_q <= 10'd0;
      cnt_q    <= 3'd0;
      y_q      <= 8'd0;
    end else begin
      case (state_q)
        StIdle: if (start) state_q <= StWait;
        StWait: if (!start) state_q <= StInit;
        StInit: begin
          result_q <= 10'd256;
          term_q   <= 10'd256;
          cnt_q    <= 3'd0;
          y_q      <= y;
          x2_q     <= x2_next;
          state_q  <= StCalc;
        end
        StCalc: begin
          term_q  <= term_next;
          state_q <= StAcc;
        end
        StAcc: begin
          result_q <= is_neg ? (result_q - term_q) : (result_q + term_q);
          cnt_q    <= cnt_q + 3'd1;
          state_q  <= (co || !gt) ? StDone : StCalc;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ps     = state_q;
  assign result = result_q;
  assign done   = (state_q == StDone);
  assign co     = (cnt_q == 3'd7);
  assign is_neg = ~cnt_q[0];

endmodule

// File: tb/tb_cosx.sv
// Self-checking bench for cosx: directed Taylor cases, handshake, reset and
// randomized operands against a series-sum reference model.
module tb_cosx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] x;
  logic [7:0] y;
  logic       done;
  logic [9:0] result;
  logic [2:0] ps;
  logic       co;
  logic       is_neg;

  int n_tests = 0;
  int n_fail  = 0;

  cosx dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .y      (y),
    .done   (done),
    .result (result),
    .ps     (ps),
    .co     (co),
    .is_neg (is_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Taylor series cos(x): partial[k] is the running sum after k+1 terms.
  function automatic void model(input int xv, input int yv, output int res,
                                output int nt, output int partial[8]);
    int c[8] = '{128, 21, 9, 5, 3, 2, 1, 1};
    int x2, t, acc;
    x2  = ((xv * xv) / 256) % 1024;
    t   = 256;
    acc = 256;
    nt  = 0;
    for (int k = 0; k < 8; k++) partial[k] = 0;
    for (int k = 0; k < 8; k++) begin
      t   = (((t * x2) / 256) * c[k] / 256) % 1024;
      acc = (k % 2 == 0) ? acc - t : acc + t;
      acc = ((acc % 1024) + 1024) % 1024;
      partial[k] = acc;
      nt = k + 1;
      if (t <= yv) break;
    end
    res = acc;
  endfunction

  task automatic run(input int xv, input int yv, input bit noisy,
                     output int got, output int got_nt);
    int exp_res, exp_nt, part[8];
    int cyc, init_cyc, done_cyc, ndone, nacc;
    bit prev_acc;
    model(xv, yv, exp_res, exp_nt, part);
    x = 10'(xv);
    y = 8'(yv);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    cyc = 0; init_cyc = -1; done_cyc = -1; ndone = 0; nacc = 0; prev_acc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (prev_acc) chk($sformatf("partial x=%0d k=%0d", xv, nacc), int'(result), part[nacc-1]);
      prev_acc = 0;
      if (ps == 3'd2 && init_cyc < 0) init_cyc = cyc;
      if (ps == 3'd4) begin
        chk("is_neg in ACC", int'(is_neg), (nacc % 2 == 0) ? 1 : 0);
        chk("co in ACC", int'(co), (nacc == 7) ? 1 : 0);
        nacc++;
        prev_acc = 1;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (init_cyc >= 0 && ps != 3'd2) begin
        // Inputs after INIT must not matter.
        x = 10'($urandom);
        y = 8'($urandom);
      end
      if (noisy && (ps == 3'd3 || ps == 3'd4)) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      if (ps == 3'd0 && done_cyc >= 0) break;
    end
    start = 1'b0;
    chk("completion within bound", (done_cyc >= 0) ? 1 : 0, 1);
    chk("single done pulse", ndone, 1);
    chk("INIT to DONE latency", done_cyc - init_cyc, 1 + 2 * exp_nt);
    chk("terms evaluated", nacc, exp_nt);
    chk($sformatf("result x=%0d y=%0d", xv, yv), int'(result), exp_res);
    got = int'(result);
    got_nt = nacc;
    @(negedge clk);
  endtask

  initial begin
    int r, nt, cyc;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    #2;
    chk("reset ps", int'(ps), 0);
    chk("reset result", int'(result), 0);
    chk("reset done", int'(done), 0);
    chk("reset co", int'(co), 0);
    chk("reset is_neg", int'(is_neg), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(268, 0, 0, r, nt);
    chk("pi/3 result const", r, 128);
    chk("pi/3 terms const", nt, 3);
    run(402, 0, 0, r, nt);
    chk("pi/2 result const", r, 10'h3FF);
    chk("pi/2 terms const", nt, 4);
    run(0, 0, 0, r, nt);
    chk("x=0 result const", r, 256);
    chk("x=0 terms const", nt, 1);
    run(268, 255, 0, r, nt);
    chk("threshold result const", r, 116);
    chk("threshold terms const", nt, 1);

    // Long start hold stays in WAIT.
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold in WAIT", int'(ps), 1);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("leave WAIT to INIT", int'(ps), 2);
    cyc = 0;
    while (!done && cyc < 40) begin @(negedge clk); cyc++; end
    chk("held-start run completes", int'(done), 1);
    @(negedge clk);

    run(402, 0, 1, r, nt);
    chk("noisy start result", r, 10'h3FF);

    // Asynchronous reset mid-CALC.
    x = 10'd402; y = 8'd0; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (ps != 3'd3 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reached CALC", int'(ps), 3);
    #2 rst = 1'b1;
    #1;
    chk("async reset ps", int'(ps), 0);
    chk("async reset result", int'(result), 0);
    chk("async reset done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    chk("no done after reset", cyc, 0);

    for (int i = 0; i < 30; i++) begin
      int xv, yv;
      xv = (i % 3 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 402));
      yv = (i % 4 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      run(xv, yv, i[0], r, nt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
